// File: rtl/pe_traffic_gen_if.sv
// Router-port bundle for a processing element: the injection channel
// (PE -> router) and the ejection channel (router -> PE). Signal names are
// taken from the PE's point of view.
interface pe_traffic_gen_if #(
  parameter int TOTAL_WIDTH = 34
);
  // injection channel
  logic [TOTAL_WIDTH-1:0] o_data;
  logic                   o_data_valid;
  logic                   i_data_ready;
  // ejection channel
  logic [TOTAL_WIDTH-1:0] i_data;
  logic                   i_data_valid;
  logic                   o_data_ready;

  // PE side
  modport master (
    output o_data, o_data_valid, o_data_ready,
    input  i_data_ready, i_data, i_data_valid
  );

  // router side
  modport slave (
    input  o_data, o_data_valid, o_data_ready,
    output i_data_ready, i_data, i_data_valid
  );
endinterface

// File: rtl/pe_traffic_gen.sv
// Processing-element traffic generator and sink. Injects PKT_LIMIT packets
// per run with destinations from a synthetic traffic pattern, throttled by
// INJ_GAP, and counts ejected (and misrouted) packets.
module pe_traffic_gen #(
  parameter int          ADDRESS     = 0,
  parameter int          ADDR_WIDTH  = 2,
  parameter int          DATA_WIDTH  = 32,
  parameter int          TOTAL_WIDTH = ADDR_WIDTH + DATA_WIDTH,
  parameter int          PKT_LIMIT   = 100,
  parameter int          PATTERN     = 0,
  parameter int          INJ_GAP     = 0,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1,
  parameter int          CNT_WIDTH   = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_start,
  pe_traffic_gen_if.master     bus,
  output logic                 o_busy,
  output logic                 o_done,
  output logic [CNT_WIDTH-1:0] o_sent_count,
  output logic [CNT_WIDTH-1:0] o_rcvd_count,
  output logic [CNT_WIDTH-1:0] o_err_count
);

  localparam int NUM_PE = 2 ** ADDR_WIDTH;
  localparam int SEQ_W  = $clog2(PKT_LIMIT + 1);
  localparam int GAP_W  = (INJ_GAP > 1) ? $clog2(INJ_GAP) : 1;

  localparam logic [ADDR_WIDTH-1:0] MY_ADDR     = ADDR_WIDTH'(ADDRESS);
  localparam logic [ADDR_WIDTH-1:0] TORNADO_OFS = ADDR_WIDTH'((NUM_PE + 1) / 2);
  localparam logic [DATA_WIDTH-1:0] PAY_BASE    = DATA_WIDTH'(PKT_LIMIT * ADDRESS);
  localparam logic [15:0]           LFSR_INIT   = LFSR_SEED ^ 16'(ADDRESS);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_LOAD = 3'd1;
  localparam logic [2:0] S_SEND = 3'd2;
  localparam logic [2:0] S_GAP  = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  logic [2:0]             r_state;
  logic [TOTAL_WIDTH-1:0] r_data;
  logic                   r_valid;
  logic [SEQ_W-1:0]       r_seq;
  logic [GAP_W-1:0]       r_gap_cnt;
  logic [15:0]            r_lfsr;
  logic [CNT_WIDTH-1:0]   r_sent;
  logic [CNT_WIDTH-1:0]   r_rcvd;
  logic [CNT_WIDTH-1:0]   r_err;

  logic [ADDR_WIDTH-1:0]  w_dest;
  logic [DATA_WIDTH-1:0]  w_payload;
  logic [TOTAL_WIDTH-1:0] w_flit;
  logic [15:0]            w_lfsr_next;
  logic                   w_start;
  logic                   w_xfer;
  logic                   w_last;
  logic [ADDR_WIDTH-1:0]  w_ej_dest;
  logic                   w_misrouted;
  logic [DATA_WIDTH-1:0]  w_unused_payload;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + CNT_WIDTH'(1);
  endfunction

  // Destination of the current packet for the selected traffic pattern.
  always_comb begin
    // NOTE: default assignment first so no path through the case leaves w_dest unassigned (no latch).
    w_dest = MY_ADDR;
    case (PATTERN)
      0: w_dest = r_lfsr[ADDR_WIDTH-1:0];
      1: w_dest = ~MY_ADDR;
      2: for (int j = 0; j < ADDR_WIDTH; j++) w_dest[j] = MY_ADDR[ADDR_WIDTH-1-j];
      3: for (int j = 0; j < ADDR_WIDTH; j++) w_dest[j] = MY_ADDR[(j + 1) % ADDR_WIDTH];
      4: for (int j = 0; j < ADDR_WIDTH; j++) w_dest[j] = MY_ADDR[(j + ADDR_WIDTH / 2) % ADDR_WIDTH];
      5: w_dest = MY_ADDR + TORNADO_OFS;
      6: w_dest = MY_ADDR + ADDR_WIDTH'(1);
      default: w_dest = MY_ADDR;
    endcase
  end

  assign w_payload   = PAY_BASE + DATA_WIDTH'(r_seq);
  assign w_flit      = {w_dest, w_payload};
  assign w_lfsr_next = {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
  assign w_start     = i_start && (r_state == S_IDLE || r_state == S_DONE);
  assign w_xfer      = r_valid && bus.i_data_ready;
  assign w_last      = (r_seq == SEQ_W'(PKT_LIMIT - 1));

  assign w_ej_dest        = bus.i_data[DATA_WIDTH +: ADDR_WIDTH];
  assign w_misrouted      = (w_ej_dest != MY_ADDR);
  assign w_unused_payload = bus.i_data[DATA_WIDTH-1:0];

  // Injection FSM: builds each flit, holds it until accepted, then spaces
  // the next one by the programmed gap. GAP presents the next flit on its
  // last counted cycle so exactly INJ_GAP cycles pass with valid low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_data    <= '0;
      r_valid   <= 1'b0;
      r_seq     <= '0;
      r_gap_cnt <= '0;
      r_lfsr    <= LFSR_INIT;
      r_sent    <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      case (r_state)
        S_IDLE, S_DONE: begin
          if (i_start) begin
            r_state <= S_LOAD;
            r_seq   <= '0;
            r_sent  <= '0;
          end
        end
        S_LOAD: begin
          r_data  <= w_flit;
          r_valid <= 1'b1;
          r_state <= S_SEND;
        end
        S_SEND: begin
          if (w_xfer) begin
            r_sent  <= sat_inc(r_sent);
            r_seq   <= r_seq + SEQ_W'(1);
            r_lfsr  <= w_lfsr_next;
            r_valid <= 1'b0;
            if (w_last) begin
              r_state <= S_DONE;
            end else if (INJ_GAP == 0) begin
              r_state <= S_LOAD;
            end else begin
              r_state   <= S_GAP;
              r_gap_cnt <= GAP_W'(INJ_GAP - 1);
            end
          end
        end
        S_GAP: begin
          if (r_gap_cnt == '0) begin
            r_data  <= w_flit;
            r_valid <= 1'b1;
            r_state <= S_SEND;
          end else begin
            r_gap_cnt <= r_gap_cnt - GAP_W'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Ejection sink: counts every ejected flit and those addressed elsewhere;
  // a new run clears the counts but still counts a flit arriving on that edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rcvd <= '0;
      r_err  <= '0;
    end else if (w_start) begin
      r_rcvd <= CNT_WIDTH'(bus.i_data_valid);
      r_err  <= CNT_WIDTH'(bus.i_data_valid && w_misrouted);
    end else if (bus.i_data_valid) begin
      r_rcvd <= sat_inc(r_rcvd);
      if (w_misrouted) r_err <= sat_inc(r_err);
    end
  end

  assign bus.o_data       = r_data;
  assign bus.o_data_valid = r_valid;
  assign bus.o_data_ready = 1'b1;
  assign o_busy           = (r_state == S_LOAD) || (r_state == S_SEND) || (r_state == S_GAP);
  assign o_done           = (r_state == S_DONE);
  assign o_sent_count     = r_sent;
  assign o_rcvd_count     = r_rcvd;
  assign o_err_count      = r_err;

endmodule
